// File: rtl/risc0_io_pkg.sv
// Shared constants for the RISC0 I/O bus: register addresses and receive-buffer sizing.
package risc0_io_pkg;

    localparam logic [3:0] IO_ADR_CNT   = 4'd0;
    localparam logic [3:0] IO_ADR_SWI   = 4'd1;
    localparam logic [3:0] IO_ADR_UART  = 4'd2;
    localparam logic [3:0] IO_ADR_STAT  = 4'd3;

    localparam int BYTE_W       = 8;
    localparam int RXFIFO_DEPTH = 16;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x BYTE_W storage: one synchronous write port, asynchronous read port.
module fifo_ram
    import risc0_io_pkg::*;
#(
    parameter int DEPTH = RXFIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem_q [0:DEPTH-1];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rs232_rx_fifo.sv
// Receive buffer between RS232R and the RISC0 I/O bus (rdy/done handshake into a FIFO).
// Optional overrun discard/flag enabled by defining RS232_RX_FIFO_OVR_EN.
module rs232_rx_fifo
    import risc0_io_pkg::*;
#(
    parameter int DEPTH = RXFIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_rdy,
    output logic              rx_done,
    input  logic              rd,
    output logic [BYTE_W-1:0] rd_data,
    output logic              rdy,
    output logic              full,
    output logic [AW:0]       count,
    output logic              ovr,
    input  logic              ovr_clr
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(1'b0);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              rx_done_q, rx_done_d;
    logic              ovr_q, ovr_d;
    logic              full_s, empty_s, take_s, push_s, pop_s, ovr_set_s;
    logic [BYTE_W-1:0] head_s;

    fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_q),
        .wdata (rx_data),
        .raddr (rd_ptr_q),
        .rdata (head_s)
    );

    // Push/pop qualification; eligibility uses the pre-pop full so a pop never frees a slot early.
    always_comb begin
        full_s  = (count_q == CNT_FULL);
        empty_s = (count_q == CNT_ZERO);
        take_s  = rx_rdy & ~rx_done_q;
        push_s  = take_s & ~full_s;
        pop_s   = rd & ~empty_s;
`ifdef RS232_RX_FIFO_OVR_EN
        ovr_set_s = take_s & full_s;
`else
        ovr_set_s = 1'b0;
`endif
    end

    // Next-state for pointers, occupancy, acknowledge and overrun flag.
    always_comb begin
        rx_done_d = push_s | ovr_set_s;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

`ifdef RS232_RX_FIFO_OVR_EN
        // A fresh overrun outranks a clear arriving in the same cycle.
        if (ovr_set_s) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
`else
        ovr_d = 1'b0;
`endif
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= CNT_ZERO;
            rx_done_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rx_done_q <= rx_done_d;
            ovr_q     <= ovr_d;
        end
    end

`ifndef RS232_RX_FIFO_OVR_EN
    logic unused_ovr_clr_s;
    assign unused_ovr_clr_s = ovr_clr;
`endif

    assign rx_done = rx_done_q;
    assign rdy     = ~empty_s;
    assign full    = full_s;
    assign count   = count_q;
    assign ovr     = ovr_q;
    assign rd_data = empty_s ? {BYTE_W{1'b0}} : head_s;

endmodule
